disp_scan: RTL

- Downstream display stage for scp_1. Consumes its eight 24-bit debug buses: out_zero, control_signal, instr_lower, instr_upper, alu, program_counter, register_1 and register_2.
- Each bus is treated as three 8-bit seven-segment patterns. The block picks one bus as the visible "page", either manually or by auto-cycling.
- It time-multiplexes the three digits onto one shared segment bus with digit enables. A one-cycle blank between digits suppresses ghosting.
- The frame contents are snapshotted, so a multi-digit value is never torn mid-frame.

---
 rtl/disp_scan_if.sv | 37 +++
 rtl/disp_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/disp_scan_if.sv
// disp_scan_if -- signal bundle between the scp_1 debug source and the
// disp_scan display stage.
//   page_sel, auto_en, freeze : page control from the source side
//   out_zero .. register_2    : eight 24-bit pages, three segment bytes each
//   seg, dig, page, tick      : display drive and status from disp_scan
// The master modport is the source/observer side; slave is disp_scan.
interface disp_scan_if;
  logic [2:0]  page_sel;
  logic        auto_en;
  logic        freeze;
  logic [23:0] out_zero;
  logic [23:0] control_signal;
  logic [23:0] instr_lower;
  logic [23:0] instr_upper;
  logic [23:0] alu;
  logic [23:0] program_counter;
  logic [23:0] register_1;
  logic [23:0] register_2;
  logic [7:0]  seg;
  logic [2:0]  dig;
  logic [2:0]  page;
  logic        tick;

  modport master (
    output page_sel, auto_en, freeze,
    output out_zero, control_signal, instr_lower, instr_upper,
    output alu, program_counter, register_1, register_2,
    input  seg, dig, page, tick
  );

  modport slave (
    input  page_sel, auto_en, freeze,
    input  out_zero, control_signal, instr_lower, instr_upper,
    input  alu, program_counter, register_1, register_2,
    output seg, dig, page, tick
  );
endinterface

// File: rtl/disp_scan.sv
// disp_scan -- three-digit seven-segment scanner for the scp_1 debug buses.
// One of eight 24-bit pages is snapshotted per frame and its three segment
// bytes are time-multiplexed onto a shared segment bus, with a one-clock
// blank between digits to suppress ghosting.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : disp_scan_if.slave (page control, eight pages in; seg/dig/page/tick out)
// Parameters: SCAN_DIV clocks per digit window (>=2), AUTO_TICKS windows per
// page in auto mode (>=1), ACTIVE_LOW selects inverted seg/dig drive.
module disp_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int AUTO_TICKS = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int AW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] DIG_OFF = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  page_q, page_d;
  logic [23:0] snap_q, snap_d;
  logic [AW-1:0] atick_q, atick_d;
  logic        advPend_q, advPend_d;
  logic        tick_q, tick_d;
  logic [7:0]  seg_q, seg_d;
  logic [2:0]  dig_q, dig_d;

  logic        lastCnt;
  logic        frameLoad;
  logic [2:0]  nextPage;
  logic [23:0] pageBus;
  logic [7:0]  segRaw;
  logic [2:0]  digRaw;

  // State register; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      page_q    <= 3'd0;
      snap_q    <= 24'd0;
      atick_q   <= '0;
      advPend_q <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      snap_q    <= snap_d;
      atick_q   <= atick_d;
      advPend_q <= advPend_d;
      tick_q    <= tick_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  // Page mux for the frame load.
  always_comb begin
    pageBus = 24'd0;
    case (nextPage)
      3'd0: pageBus = bus.out_zero;
      3'd1: pageBus = bus.control_signal;
      3'd2: pageBus = bus.instr_lower;
      3'd3: pageBus = bus.instr_upper;
      3'd4: pageBus = bus.alu;
      3'd5: pageBus = bus.program_counter;
      3'd6: pageBus = bus.register_1;
      default: pageBus = bus.register_2;
    endcase
  end

  // Next-state logic for the scan FSM, frame loader and auto timer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    page_d    = page_q;
    snap_d    = snap_q;
    atick_d   = atick_q;
    advPend_d = advPend_q;
    segRaw    = 8'd0;
    digRaw    = 3'd0;

    lastCnt = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d   = lastCnt ? '0 : cnt_q + 1'b1;
    // tick is registered, so it is asserted from the count we are moving to.
    tick_d  = (cnt_d == CW'(SCAN_DIV - 1));

    if (lastCnt) begin
      idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      state_d = BLANK;
    end else if (state_q == BLANK) begin
      state_d = SHOW;
    end

    nextPage = bus.auto_en ? (advPend_q ? page_q + 3'd1 : page_q) : bus.page_sel;

    // A new frame is taken only while digit 0 is blanked, so a frame is never torn.
    frameLoad = (state_q == BLANK) && (idx_q == 2'd0) && !bus.freeze;
    if (frameLoad) begin
      page_d    = nextPage;
      snap_d    = pageBus;
      advPend_d = 1'b0;
    end

    // Ticks always land in SHOW, so this never collides with the load clearing advPend.
    if (lastCnt && !bus.freeze && bus.auto_en) begin
      if (atick_q == AW'(AUTO_TICKS - 1)) begin
        atick_d   = '0;
        advPend_d = 1'b1;
      end else begin
        atick_d = atick_q + 1'b1;
      end
    end

    // Drive from the upcoming state and snapshot so the flops line up with the FSM.
    if (state_d == SHOW) begin
      case (idx_d)
        2'd0:    segRaw = snap_d[7:0];
        2'd1:    segRaw = snap_d[15:8];
        default: segRaw = snap_d[23:16];
      endcase
      digRaw = 3'b001 << idx_d;
    end
    seg_d = ACTIVE_LOW ? ~segRaw : segRaw;
    dig_d = ACTIVE_LOW ? ~digRaw : digRaw;
  end

  assign bus.seg  = seg_q;
  assign bus.dig  = dig_q;
  assign bus.page = page_q;
  assign bus.tick = tick_q;

endmodule
